// File: rtl/fpna_cfg_pkg.sv
// FPNA config loader shared types: FSM states, frame defaults, CRC step.
// Imported by the loader top and the serial CRC-8 engine.
package fpna_cfg_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] POLY_DEFAULT = 8'h07;
  localparam int         CRC_LEN      = 8;

  function automatic logic [7:0] crc8_step(
    input logic [7:0] c,
    input logic       b,
    input logic [7:0] poly
  );
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/fpna_crc8_serial.sv
// Serial MSB-first CRC-8 (init 0, no reflect/xorout).
// Ports: clk, rst_n, clr, en, bit_in -> crc remainder.
module fpna_crc8_serial
  import fpna_cfg_pkg::*;
#(
  parameter logic [7:0] POLY = POLY_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 8'h00;
    end else if (clr) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= crc8_step(crc, bit_in, POLY);
    end
  end

endmodule

// File: rtl/fpna_config_loader.sv
// Framed CRC-8 checked config loader: sync hunt, payload stage, commit.
// Ports: clk, rst_n, config_en, bs_in -> bs_out, cfg_active, flags, busy.
module fpna_config_loader
  import fpna_cfg_pkg::*;
#(
  parameter int         CFG_BITS      = 400,
  parameter logic [7:0] SYNC_WORD     = SYNC_DEFAULT,
  parameter logic [7:0] CRC_POLY      = POLY_DEFAULT,
  parameter int         STALL_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                config_en,
  input  logic                bs_in,
  output logic                bs_out,
  output logic [CFG_BITS-1:0] cfg_active,
  output logic                cfg_update,
  output logic                cfg_loaded,
  output logic                crc_err,
  output logic                busy
);

  localparam int CW = $clog2(CFG_BITS);
  localparam int SW = (STALL_TIMEOUT > 0) ?
                      $clog2(STALL_TIMEOUT + 1) : 1;

  state_t              state;
  state_t              state_n;
  logic [7:0]          window;
  logic [7:0]          win_nx;
  logic [CW-1:0]       bit_cnt;
  logic [SW-1:0]       stall_cnt;
  logic [CFG_BITS-1:0] stage;
  logic [7:0]          crc;
  logic [7:0]          crc_nx;
  logic                in_frame;
  logic                crc_en;
  logic                sync_hit;
  logic                last_load;
  logic                last_chk;
  logic                timeout;
  logic                crc_ok;

  assign in_frame  = (state != HUNT);
  assign win_nx    = {window[6:0], bs_in};
  assign crc_en    = config_en && in_frame;
  assign sync_hit  = (state == HUNT) && config_en &&
                     (win_nx == SYNC_WORD);
  assign last_load = (state == LOAD) && config_en &&
                     (bit_cnt == CW'(CFG_BITS - 1));
  assign last_chk  = (state == CHECK) && config_en &&
                     (bit_cnt == CW'(CRC_LEN - 1));
  assign timeout   = (STALL_TIMEOUT != 0) && in_frame &&
                     !config_en &&
                     (stall_cnt == SW'(STALL_TIMEOUT - 1));
  // remainder including the bit sampled on this edge
  assign crc_nx    = crc8_step(crc, bs_in, CRC_POLY);
  assign crc_ok    = (crc_nx == 8'h00);
  assign bs_out    = stage[CFG_BITS-1];

  fpna_crc8_serial #(
    .POLY (CRC_POLY)
  ) u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (sync_hit),
    .en     (crc_en),
    .bit_in (bs_in),
    .crc    (crc)
  );

  always_comb begin
    state_n = state;
    unique case (1'b1)
      sync_hit:          state_n = LOAD;
      last_load:         state_n = CHECK;
      last_chk, timeout: state_n = HUNT;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != HUNT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window    <= 8'h00;
      bit_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if ((state == HUNT) && config_en) begin
        window <= win_nx;
      end else if (timeout) begin
        window <= 8'h00;
      end
      if (sync_hit || last_load || last_chk) begin
        bit_cnt <= '0;
      end else if (crc_en) begin
        bit_cnt <= bit_cnt + CW'(1);
      end
      if (config_en || !in_frame || timeout) begin
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage      <= '0;
      cfg_active <= '0;
      cfg_update <= 1'b0;
      cfg_loaded <= 1'b0;
      crc_err    <= 1'b0;
    end else begin
      cfg_update <= last_chk && crc_ok;
      if ((state == LOAD) && config_en) begin
        stage <= {stage[CFG_BITS-2:0], bs_in};
      end
      if (last_chk && crc_ok) begin
        cfg_active <= stage;
        cfg_loaded <= 1'b1;
      end
      if (sync_hit) begin
        crc_err <= 1'b0;
      end else if (last_chk && !crc_ok) begin
        crc_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpna_config_loader.sv
// Bench for fpna_config_loader: 16-bit and 400-bit instances,
// frame-level reference model plus literal expectations.
module tb_fpna_config_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic config_en = 1'b0;
  logic bs_in = 1'b0;
  logic run = 1'b0;

  always #5 clk = ~clk;

  logic        a_bs, a_upd, a_ld, a_err, a_busy;
  logic [15:0] a_act;
  logic        b_bs, b_upd, b_ld, b_err, b_busy;
  logic [399:0] b_act;
  logic en_a, en_b;

  assign en_a = config_en & ~sel;
  assign en_b = config_en & sel;

  fpna_config_loader #(
    .CFG_BITS (16),
    .STALL_TIMEOUT (20)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .config_en (en_a), .bs_in (bs_in),
    .bs_out (a_bs), .cfg_active (a_act),
    .cfg_update (a_upd), .cfg_loaded (a_ld),
    .crc_err (a_err), .busy (a_busy)
  );

  fpna_config_loader #(
    .CFG_BITS (400)
  ) dut400 (
    .clk (clk), .rst_n (rst_n),
    .config_en (en_b), .bs_in (bs_in),
    .bs_out (b_bs), .cfg_active (b_act),
    .cfg_update (b_upd), .cfg_loaded (b_ld),
    .crc_err (b_err), .busy (b_busy)
  );

  logic [399:0] d_act;
  logic d_bs, d_upd, d_ld, d_err, d_busy;
  assign d_act  = sel ? b_act : {384'b0, a_act};
  assign d_bs   = sel ? b_bs : a_bs;
  assign d_upd  = sel ? b_upd : a_upd;
  assign d_ld   = sel ? b_ld : a_ld;
  assign d_err  = sel ? b_err : a_err;
  assign d_busy = sel ? b_busy : a_busy;

  int total = 0;
  int bad = 0;
  int nprint = 0;
  int n_upd = 0;

  // CRC as remainder of payload * x^8 modulo x^8 + poly
  function automatic logic [7:0] crc_ref(
    input logic [399:0] p, input int n);
    logic [8:0] r;
    r = 9'h000;
    for (int i = n - 1; i >= 0; i--) begin
      r = {r[7:0], p[i]};
      if (r[8]) r = r ^ 9'h107;
    end
    for (int i = 0; i < 8; i++) begin
      r = {r[7:0], 1'b0};
      if (r[8]) r = r ^ 9'h107;
    end
    return r[7:0];
  endfunction

  // frame-level model
  int L, T;
  assign L = sel ? 400 : 16;
  assign T = sel ? 255 : 20;

  logic [7:0]   m_win;
  int           m_pos;
  int           m_stall;
  logic [415:0] m_bits;
  logic [415:0] m_full;
  logic [399:0] m_stage, m_active, m_pay, m_mask;
  logic [7:0]   m_w_nx, m_got, m_exp;
  logic m_upd, m_loaded, m_err, m_busy;

  assign m_w_nx = {m_win[6:0], bs_in};
  assign m_full = {m_bits[414:0], bs_in};
  assign m_mask = {400{1'b1}} >> (400 - L);
  assign m_pay  = m_full[407:8] & m_mask;
  assign m_got  = m_full[7:0];
  assign m_exp  = crc_ref(m_pay, L);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_win <= 8'h00; m_pos <= -1; m_stall <= 0;
      m_bits <= '0; m_stage <= '0; m_active <= '0;
      m_upd <= 1'b0; m_loaded <= 1'b0;
      m_err <= 1'b0; m_busy <= 1'b0;
    end else begin
      m_upd <= 1'b0;
      if (config_en) begin
        m_stall <= 0;
        if (m_pos < 0) begin
          m_win <= m_w_nx;
          if (m_w_nx == 8'hA5) begin
            m_pos <= 0; m_err <= 1'b0; m_busy <= 1'b1;
          end
        end else begin
          m_bits <= m_full;
          if (m_pos < L)
            m_stage <= ((m_stage << 1) | 400'(bs_in)) & m_mask;
          if (m_pos == L + 7) begin
            if (m_exp == m_got) begin
              m_active <= m_pay; m_upd <= 1'b1;
              m_loaded <= 1'b1;
            end else begin
              m_err <= 1'b1;
            end
            m_pos <= -1; m_busy <= 1'b0;
          end else begin
            m_pos <= m_pos + 1;
          end
        end
      end else if (m_pos >= 0) begin
        if (m_stall + 1 == T) begin
          m_pos <= -1; m_busy <= 1'b0;
          m_win <= 8'h00; m_stall <= 0;
        end else begin
          m_stall <= m_stall + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      total++;
      if (d_act !== m_active || d_upd !== m_upd ||
          d_ld !== m_loaded || d_err !== m_err ||
          d_busy !== m_busy || d_bs !== m_stage[L-1]) begin
        bad++;
        if (nprint < 8)
          $display("FAIL model t=%0t upd/ld/err/busy/bs got %b%b%b%b%b want %b%b%b%b%b act got %h want %h",
                   $time, d_upd, d_ld, d_err, d_busy, d_bs,
                   m_upd, m_loaded, m_err, m_busy, m_stage[L-1],
                   d_act, m_active);
        nprint++;
      end
    end
  end

  always @(negedge clk) if (d_upd) n_upd++;

  task automatic chk1(input string name, input logic got,
                      input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, got, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [399:0] got,
                      input logic [399:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic chki(input string name, input int got,
                      input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic put(input logic e, input logic b);
    @(negedge clk);
    config_en = e;
    bs_in = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(1'b0, 1'b0);
  endtask

  task automatic send(input logic [399:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) put(1'b1, v[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    config_en = 1'b0;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    n_upd = 0;
  endtask

  logic [399:0] p;
  logic [7:0]   c;
  logic [31:0]  fr;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle(2);
    chkv("rst_active", d_act, 400'h0);
    chk1("rst_upd", d_upd, 1'b0);
    chk1("rst_loaded", d_ld, 1'b0);
    chk1("rst_err", d_err, 1'b0);
    chk1("rst_busy", d_busy, 1'b0);
    chk1("rst_bs_out", d_bs, 1'b0);
    chkv("ref_1234", 400'(crc_ref(400'h1234, 16)), 400'hF1);
    chkv("ref_beef", 400'(crc_ref(400'hBEEF, 16)), 400'h1A);
    rst_n = 1'b1;
    run = 1'b1;

    // good frame, contiguous strobes
    send(400'hA5, 8);
    send(400'h1234, 16);
    send(400'h78, 7);
    put(1'b1, 1'b1);
    chk1("t1_busy_31", d_busy, 1'b1);
    chk1("t1_upd_31", d_upd, 1'b0);
    put(1'b0, 1'b0);
    chk1("t1_upd_32", d_upd, 1'b1);
    chkv("t1_active", d_act, 400'h1234);
    chk1("t1_loaded", d_ld, 1'b1);
    chk1("t1_err", d_err, 1'b0);
    chk1("t1_busy_end", d_busy, 1'b0);
    put(1'b0, 1'b0);
    chk1("t1_upd_drop", d_upd, 1'b0);
    idle(2);
    chki("t1_pulses", n_upd, 1);

    // bad CRC, then good frame clears the error
    do_reset();
    send(400'hA5, 8);
    send(400'h1234, 16);
    send(400'hF0, 8);
    idle(2);
    chk1("t2_err", d_err, 1'b1);
    chkv("t2_active", d_act, 400'h0);
    chk1("t2_loaded", d_ld, 1'b0);
    chki("t2_no_upd", n_upd, 0);
    send(400'hA5, 8);
    put(1'b0, 1'b0);
    chk1("t2_err_clr", d_err, 1'b0);
    chk1("t2_busy", d_busy, 1'b1);
    send(400'hBEEF, 16);
    send(400'h1A, 8);
    idle(3);
    chkv("t2_active2", d_act, 400'hBEEF);
    chk1("t2_err2", d_err, 1'b0);
    chki("t2_pulses", n_upd, 1);

    // noise before sync
    do_reset();
    send(400'h005AA4, 24);
    send(400'h52, 7);
    put(1'b1, 1'b1);
    chk1("t3_busy_pre", d_busy, 1'b0);
    put(1'b1, 1'b0);
    chk1("t3_busy_sync", d_busy, 1'b1);
    send(400'h1234, 15);
    send(400'hF1, 8);
    idle(3);
    chkv("t3_active", d_act, 400'h1234);
    chki("t3_pulses", n_upd, 1);

    // random gaps between strobes
    do_reset();
    fr = 32'hA51234F1;
    for (int i = 31; i >= 0; i--) begin
      idle($urandom_range(0, 10));
      put(1'b1, fr[i]);
    end
    idle(3);
    chkv("t4_active", d_act, 400'h1234);
    chk1("t4_err", d_err, 1'b0);
    chki("t4_pulses", n_upd, 1);

    // stall mid-load times out, prior config kept
    n_upd = 0;
    send(400'hA5, 8);
    send(400'h16, 5);
    idle(19);
    put(1'b0, 1'b0);
    chk1("t5_busy_19", d_busy, 1'b1);
    put(1'b0, 1'b0);
    chk1("t5_busy_20", d_busy, 1'b0);
    chkv("t5_active", d_act, 400'h1234);
    send(400'hA5BEEF1A, 32);
    idle(3);
    chkv("t5_recover", d_act, 400'hBEEF);
    chki("t5_pulses", n_upd, 1);

    // async reset mid-load
    send(400'hA5, 8);
    send(400'hA, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chkv("t6_active", d_act, 400'h0);
    chk1("t6_busy", d_busy, 1'b0);
    chk1("t6_loaded", d_ld, 1'b0);
    chk1("t6_upd", d_upd, 1'b0);
    chk1("t6_err", d_err, 1'b0);
    chk1("t6_bs_out", d_bs, 1'b0);
    config_en = 1'b0;
    idle(1);
    rst_n = 1'b1;

    // 400-bit instance, random payload
    @(negedge clk);
    rst_n = 1'b0;
    sel = 1'b1;
    idle(2);
    rst_n = 1'b1;
    n_upd = 0;
    for (int i = 0; i < 400; i++) p[i] = 1'($urandom_range(0, 1));
    c = crc_ref(p, 400);
    send(400'hA5, 8);
    send(p, 400);
    send(400'(c), 8);
    idle(3);
    chkv("t7_active", d_act, p);
    chk1("t7_loaded", d_ld, 1'b1);
    chki("t7_pulses", n_upd, 1);
    send(400'hA5, 8);
    send(~p, 400);
    send(400'(crc_ref(~p, 400) ^ 8'h01), 8);
    idle(3);
    chk1("t7_err", d_err, 1'b1);
    chkv("t7_kept", d_act, p);

    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpna_config_loader.md
# fpna_config_loader

Framed, CRC-checked bitstream loader for the FPNA fabric; successor to the plain config shift chain in the neurochip top. Hunts for a sync word on the serial config pin, shifts a parametrised-length payload into a staging register, checks a trailing CRC-8, and only then commits the payload to the active configuration register driving the fabric. A bad or stalled frame never disturbs the active configuration.

## Interface
- `CFG_BITS`, 400: payload length in bits, ≥ 9.
- `SYNC_WORD`, 8'hA5: frame start pattern, MSB first.
- `CRC_POLY`, 8'h07: CRC-8 polynomial, init 0x00, no reflection, no xorout.
- `STALL_TIMEOUT`, 255: consecutive `config_en`-low cycles mid-frame before abort; 0 disables.

- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `config_en`  in  1  bit strobe; `bs_in` is sampled on each rising `clk` with `config_en` high.
- `bs_in`  in  1  serial bitstream.
- `bs_out`  out  1  readback: `stage[CFG_BITS-1]`.
- `cfg_active`  out  CFG_BITS  committed configuration.
- `cfg_update`  out  1  one-cycle pulse on commit.
- `cfg_loaded`  out  1  sticky; set on first commit.
- `crc_err`  out  1  sticky; set on CRC mismatch, cleared on next sync match.
- `busy`  out  1  high in LOAD or CHECK.

## Operation
- Frame: SYNC_WORD (8 bits), payload (CFG_BITS bits), CRC (8 bits), all MSB first.
- States:
  - HUNT: an 8-bit window shifts in each strobe. On `window == SYNC_WORD` (including the current bit), go to LOAD, clear CRC, bit counter and `crc_err`.
  - LOAD: each strobe shifts `stage <= {stage[CFG_BITS-2:0], bs_in}` and updates the CRC. After CFG_BITS strobes, go to CHECK.
  - CHECK: 8 strobes feed the CRC register only. After the 8th strobe:
    - CRC == 0: copy `stage` to `cfg_active`, pulse `cfg_update`, set `cfg_loaded`.
    - Otherwise: set `crc_err`.
    - Either way, return to HUNT.
- The first payload bit lands in `cfg_active[CFG_BITS-1]`.
- Serial CRC per bit: `fb = crc[7] ^ bit`; `crc <= {crc[6:0],0} ^ (fb ? CRC_POLY : 0)`.
- `config_en` low in any state pauses everything; no state or counter advances.
- Stall counter: counts low cycles in LOAD/CHECK and resets on any strobe. Reaching STALL_TIMEOUT returns to HUNT. `cfg_active` and `crc_err` are unchanged; the window is cleared.
- HUNT window is not cleared after a frame ends, so back-to-back frames are accepted with no gap.
- The stage register shifts only in LOAD. It retains the last frame, whether good or bad, for readback on `bs_out` during the next load.

## Timing
- Reset values: state HUNT; `stage` 0; `cfg_active` 0; `bs_out` 0; `cfg_update` 0; `cfg_loaded` 0; `crc_err` 0; `busy` 0; counters and window 0.
- All outputs are registered.
- `cfg_active`, `cfg_update` and `crc_err` change on the same edge that samples the final CRC bit. `cfg_update` is high for exactly one cycle.
- `busy` rises on the edge sampling the last sync bit. It falls on the edge sampling the last CRC bit, or on the timeout edge.
- Minimum frame is CFG_BITS+16 strobes. No dead cycle is needed between frames.
- `rst_n` low mid-frame: immediate return to reset values. A partial frame is lost, and `cfg_active` returns to 0.
- Bit counter width is `$clog2(CFG_BITS)`. Stall counter width is `$clog2(STALL_TIMEOUT+1)`. No wrap occurs within legal operation.

## Structure
- Package `fpna_cfg_pkg`:
  - state enum (HUNT, LOAD, CHECK);
  - default SYNC_WORD and CRC_POLY constants;
  - CRC length constant (8).
- Sub-module `fpna_crc8_serial`: clear, enable and bit inputs; 8-bit remainder output; parametrised polynomial.
- Top-level FSM, stage/active registers and stall counter live in `fpna_config_loader`.

## Test plan
Use CFG_BITS=16 unless noted. The frame for payload 0x1234 is 0xA5, 0x1234, CRC 0xF1.
- Good frame, contiguous strobes:
  - `cfg_active = 0x1234`;
  - one `cfg_update` pulse on the 32nd strobe edge;
  - `cfg_loaded = 1`, `crc_err = 0`.
- Same frame with CRC 0xF0:
  - `crc_err = 1`, no `cfg_update`, `cfg_active` stays 0.
  - A following good frame with payload 0xBEEF and a correct CRC commits it and clears `crc_err` at its sync match.
- Noise before sync (0x00, 0x5A, 0xA4, then the good frame):
  - exactly one commit, of 0x1234;
  - `busy` is low until the sync match.
- Good frame with `config_en` toggling at random, gaps ≤ 10 cycles: same result as the contiguous case.
- Stall after 5 payload bits with `STALL_TIMEOUT=20`:
  - the 20th idle cycle returns the FSM to HUNT and drops `busy`;
  - the prior `cfg_active` is unchanged.
- `rst_n` pulsed low mid-LOAD after one good commit: all outputs read 0 asynchronously. Also run CFG_BITS=400 with a random payload against a CRC reference model.
